nios_system_onchip_memory_burst: RTL and testbench
==================================================

// Module: nios_system_onchip_memory_burst
// PURPOSE
//  Parametrised on-chip RAM exposed as an Avalon-MM pipelined slave, with burst reads and writes.
//  Adds readdatavalid, waitrequest, burstcount and an error response for out-of-range addresses.
//  Supports one or two cycles of read latency.
//  Sits on the Nios II data/instruction master as program/data memory.
//  Intended to replace fixed single-port RAM slaves in new systems.
// PARAMETERS
//  DATA_WIDTH   32          data bus width; multiple of 8
//  DEPTH        32000       words implemented; need not be a power of two
//  ADDR_WIDTH   15          word-address width; DEPTH <= 2**ADDR_WIDTH
//  BURST_WIDTH  4           burstcount width; max burst = 2**(BURST_WIDTH-1) = 8
//  OUT_REG      1           0: read latency 1; 1: extra output register, read latency 2
//  INIT_FILE    "nios_system_onchip_memory_burst.hex"   power-up contents
// PORTS
//  clk            in   1              system clock
//  reset_n        in   1              asynchronous active-low reset
//  clken          in   1              clock enable; low freezes FSM and read pipeline
//  chipselect     in   1              slave select; qualifies read and write
//  read           in   1              read command
//  write          in   1              write command / write beat
//  address        in   ADDR_WIDTH     word address; sampled at command acceptance only
//  byteenable     in   DATA_WIDTH/8   per-byte write enable; all beats
//  burstcount     in   BURST_WIDTH    beats in burst; sampled at command acceptance
//  writedata      in   DATA_WIDTH     write data
//  waitrequest    out  1              slave stall
//  readdata       out  DATA_WIDTH     read data, valid with readdatavalid
//  readdatavalid  out  1              one pulse per read beat
//  response       out  2              00 OKAY, 10 SLVERR; valid with readdatavalid
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - waitrequest=1, readdata=0, readdatavalid=0, response=00.
//   - FSM=IDLE.
//   - waitrequest drops at the first clk edge with reset_n high.
//   - RAM contents are not reset.
//  Transfer accepted when chipselect & (read|write) & !waitrequest & clken.
//  Burst length: burstcount 0 is treated as 1; burstcount > max is clamped to max.
//  FSM states:
//   IDLE:
//    - write: beat 0 is written at address. Next state is WBURST if count>1, else IDLE.
//    - read: beat 0 is issued. Next state is RBURST if count>1, else IDLE.
//    - read & write together: write wins; read is ignored.
//   RBURST:
//    - waitrequest=1.
//    - One beat issued per clken cycle, address incrementing.
//    - Returns to IDLE after the last beat is issued.
//   WBURST:
//    - waitrequest=0.
//    - Each cycle with chipselect & write & clken writes one beat at the internal incremented address.
//    - Returns to IDLE after the last beat.
//    - Cycles without write are idle; read in WBURST is ignored.
//  Read latency:
//   - readdatavalid asserts exactly 1+OUT_REG clken cycles after a beat is issued.
//   - Back-to-back issue gives back-to-back valids; no gaps inside a burst.
//  Out-of-range address (addr >= DEPTH), evaluated per beat:
//   - Write is suppressed.
//   - Read returns readdata=0 with response=10.
//   - A burst crossing DEPTH errors only on the out-of-range beats.
//   - The internal address does not wrap below 2**ADDR_WIDTH.
//   - At 2**ADDR_WIDTH-1 +1 the address wraps to 0, and the error rule still applies.
//  Read-after-write to the same address in the next cycle returns the new data (no stale read).
//  clken=0:
//   - waitrequest forced 1.
//   - FSM, beat counter and read pipeline hold.
//   - readdatavalid forced 0 and re-presented when clken returns.
//  reset_n asserted mid-burst:
//   - Burst is abandoned and in-flight read beats are discarded.
//   - Memory writes already done are kept.
// STRUCTURE
//  Shared package nios_system_mem_pkg.vh holds:
//   - FSM state encodings (IDLE/RBURST/WBURST).
//   - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
//  Sub-module nios_system_ram_core:
//   - Inferred single-port byte-enabled RAM with synchronous read.
//   - Parameters DATA_WIDTH, DEPTH, ADDR_WIDTH, INIT_FILE.
//  Top holds:
//   - FSM, beat counter, address incrementer and range check.
//   - Valid/response shift pipeline of depth 1+OUT_REG.
// TESTING
//  T1 reset: hold reset_n=0 -> waitrequest=1, readdatavalid=0; release -> waitrequest=0 next edge.
//  T2 single write/read:
//   - Stimulus: write 0xDEADBEEF @0x10, be=4'b0101; read @0x10 (OUT_REG=1).
//   - Expect: readdata=0x00AD00EF (initial 0) two cycles after issue; response=00.
//  T3 write burst:
//   - Stimulus: burstcount=4 @0x100, data 1..4, then read burst of 4 @0x100.
//   - Expect: 4 consecutive readdatavalid with data 1,2,3,4.
//   - Expect: waitrequest=1 for 3 cycles after read accept.
//  T4 range error:
//   - Stimulus: read burst of 3 @DEPTH-2 (31998).
//   - Expect: beats 0,1 OKAY with stored data; beat 2 response=10, readdata=0.
//   - Stimulus: write @32000.
//   - Expect: no RAM change.
//  T5 clken stall:
//   - Stimulus: drop clken for 3 cycles mid read burst of 8.
//   - Expect: no valids during stall; total 8 valids, in order, data intact.
//  T6 reset mid-burst:
//   - Stimulus: assert reset_n=0 after 2 of 8 read beats issued.
//   - Expect: no further readdatavalid; FSM=IDLE.
//   - Expect: a new single read after release works with correct latency.

Source files
------------

// File: rtl/nios_system_mem_pkg.sv
// Shared definitions for the burst-capable on-chip memory slave.
package nios_system_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RBURST = 2'd1,
        ST_WBURST = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/nios_system_ram_core.sv
// Single-port byte-enabled RAM with registered (synchronous) read.
// Contents are never reset; the init file is attached as a RAM attribute.
module nios_system_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32000,
    parameter int ADDR_WIDTH = 15,
    parameter     INIT_FILE  = "nios_system_onchip_memory_burst.hex"
) (
    input  logic                    clk,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes and registered read; read data holds when not enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/nios_system_onchip_memory_burst.sv
// Avalon-MM pipelined burst slave around an on-chip RAM, with SLVERR for
// beats addressed at or beyond DEPTH and 1 or 2 cycles of read latency.
module nios_system_onchip_memory_burst
    import nios_system_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32000,
    parameter int ADDR_WIDTH  = 15,
    parameter int BURST_WIDTH = 4,
    parameter int OUT_REG     = 1,
    parameter     INIT_FILE   = "nios_system_onchip_memory_burst.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [BURST_WIDTH-1:0]  burstcount,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic [1:0]              response
);

    localparam logic [BURST_WIDTH-1:0] MAX_BURST = BURST_WIDTH'(2 ** (BURST_WIDTH - 1));
    localparam logic [BURST_WIDTH-1:0] ONE_BEAT  = BURST_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]    DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state, state_nxt;
    logic [BURST_WIDTH-1:0]  beats_q, beats_nxt, burst_len;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt, beat_addr;
    logic                    rdy_q;
    logic                    accept;
    logic                    beat_rd, beat_wr, beat_ok;
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    v1, e1;
    logic                    v_out, e_out;
    logic [DATA_WIDTH-1:0]   d_out;

    // rdy_q keeps the slave stalled until the first edge after reset release.
    assign waitrequest = !rdy_q || !clken || (state == ST_RBURST);
    assign accept      = chipselect && (read || write) && !waitrequest;
    assign beat_ok     = ({1'b0, beat_addr} < DEPTH_LIM);

    // Burst length normalisation: 0 means one beat, oversize clamps to max.
    always_comb begin
        burst_len = burstcount;
        if (burstcount == '0) begin
            burst_len = ONE_BEAT;
        end else if (burstcount > MAX_BURST) begin
            burst_len = MAX_BURST;
        end
    end

    // Next state, beat counter, beat address and per-cycle RAM command.
    always_comb begin
        state_nxt = state;
        beats_nxt = beats_q;
        addr_nxt  = addr_q;
        beat_addr = addr_q;
        beat_rd   = 1'b0;
        beat_wr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    beat_addr = address;
                    addr_nxt  = address + ADDR_ONE;
                    beats_nxt = burst_len - ONE_BEAT;
                    if (write) begin
                        beat_wr   = 1'b1;
                        state_nxt = (burst_len > ONE_BEAT) ? ST_WBURST : ST_IDLE;
                    end else begin
                        beat_rd   = 1'b1;
                        state_nxt = (burst_len > ONE_BEAT) ? ST_RBURST : ST_IDLE;
                    end
                end
            end
            ST_RBURST: begin
                if (clken) begin
                    beat_rd   = 1'b1;
                    addr_nxt  = addr_q + ADDR_ONE;
                    beats_nxt = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WBURST: begin
                if (chipselect && write && !waitrequest) begin
                    beat_wr   = 1'b1;
                    addr_nxt  = addr_q + ADDR_ONE;
                    beats_nxt = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM, beat counter and address register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            beats_q <= '0;
            addr_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            beats_q <= beats_nxt;
            addr_q  <= addr_nxt;
            rdy_q   <= 1'b1;
        end
    end

    nios_system_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .rd_en (beat_rd && beat_ok),
        .wr_en (beat_wr && beat_ok),
        .be    (byteenable),
        .addr  (beat_addr),
        .wdata (writedata),
        .rdata (ram_q)
    );

    // First pipeline stage: aligns valid/error flags with the RAM read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            e1 <= 1'b0;
        end else if (clken) begin
            v1 <= beat_rd;
            e1 <= beat_rd && !beat_ok;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  v2, e2;
            logic [DATA_WIDTH-1:0] d2;

            // Optional output register; error beats are zeroed on the way in.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else if (clken) begin
                    v2 <= v1;
                    e2 <= e1;
                    d2 <= (v1 && !e1) ? ram_q : '0;
                end
            end

            assign v_out = v2;
            assign e_out = e2;
            assign d_out = d2;
        end else begin : g_direct
            assign v_out = v1;
            assign e_out = e1;
            assign d_out = (v1 && !e1) ? ram_q : '0;
        end
    endgenerate

    // A pending beat is hidden while clken is low and shown again afterwards.
    assign readdatavalid = v_out && clken;
    assign readdata      = d_out;
    assign response      = (v_out && e_out) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_nios_system_onchip_memory_burst.sv
// Scoreboard bench for the burst memory slave (OUT_REG=1, latency 2).
module tb_nios_system_onchip_memory_burst;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 32000;
    localparam int MAXB  = 8;

    logic          clk = 1'b0;
    logic          reset_n, clken, chipselect, read, write;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic [BW-1:0] burstcount;
    logic [DW-1:0] writedata;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic [1:0]    response;

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;

    logic [31:0] model [int];
    logic [31:0] exp_d [$];
    logic [1:0]  exp_r [$];
    logic [31:0] wbuf [8];
    logic [31:0] ed;
    logic [1:0]  er;

    nios_system_onchip_memory_burst #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .BURST_WIDTH (BW),
        .OUT_REG     (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .address       (address),
        .byteenable    (byteenable),
        .burstcount    (burstcount),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .response      (response)
    );

    always #5 clk = ~clk;

    // Output monitor: every valid beat must match the head of the scoreboard.
    always @(negedge clk) begin
        #3;
        if (readdatavalid) begin
            nvalid++;
            checks++;
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: readdatavalid=1 required=0 (nothing outstanding)");
            end else begin
                ed = exp_d.pop_front();
                er = exp_r.pop_front();
                checks++;
                if (readdata !== ed) begin
                    failures++;
                    $display("FAIL readdata: got=%h required=%h", readdata, ed);
                end
                checks++;
                if (response !== er) begin
                    failures++;
                    $display("FAIL response: got=%b required=%b", response, er);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mget(input int a);
        if (model.exists(a)) return model[a];
        return '0;
    endfunction

    task automatic idle();
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_write(input int a, input int n, input logic [3:0] be);
        int g;
        int ma;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chipselect = 1'b1;
            write      = 1'b1;
            read       = 1'b0;
            address    = AW'(a);
            burstcount = BW'(n);
            byteenable = be;
            writedata  = wbuf[i];
            #1;
            g = 0;
            while (waitrequest && g < 50) begin
                @(negedge clk);
                #1;
                g++;
            end
            checks++;
            if (waitrequest) begin
                failures++;
                $display("FAIL write_accept: waitrequest=%0d required=0 within 50 cycles", waitrequest);
            end
            @(posedge clk);
            ma = (a + i) % (1 << AW);
            if (ma < DEPTH) begin
                w = mget(ma);
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) w[8*b +: 8] = wbuf[i][8*b +: 8];
                end
                model[ma] = w;
            end
        end
    endtask

    // Issues one read command, pushes expected beats, returns #1 after the
    // negedge following acceptance with read deasserted.
    task automatic bus_read(input int a, input int cnt);
        int g;
        int n;
        int ma;
        n = (cnt == 0) ? 1 : ((cnt > MAXB) ? MAXB : cnt);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = AW'(a);
        burstcount = BW'(cnt);
        byteenable = 4'hF;
        #1;
        g = 0;
        while (waitrequest && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        checks++;
        if (waitrequest) begin
            failures++;
            $display("FAIL read_accept: waitrequest=%0d required=0 within 50 cycles", waitrequest);
        end
        for (int i = 0; i < n; i++) begin
            ma = (a + i) % (1 << AW);
            if (ma < DEPTH) begin
                exp_d.push_back(mget(ma));
                exp_r.push_back(2'b00);
            end else begin
                exp_d.push_back(32'h0);
                exp_r.push_back(2'b10);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while (exp_d.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_d.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: outstanding=%0d required=0", tag, exp_d.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (waitrequest !== 1'b1) begin failures++; $display("FAIL rst_waitrequest: got=%b required=1", waitrequest); end
        checks++;
        if (readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_valid: got=%b required=0", readdatavalid); end
        checks++;
        if (readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata: got=%h required=00000000", readdata); end
        checks++;
        if (response !== 2'b00) begin failures++; $display("FAIL rst_response: got=%b required=00", response); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (waitrequest !== 1'b1) begin failures++; $display("FAIL rel_wait_before_edge: got=%b required=1", waitrequest); end
        @(negedge clk);
        #1;
        checks++;
        if (waitrequest !== 1'b0) begin failures++; $display("FAIL rel_wait_after_edge: got=%b required=0", waitrequest); end
    endtask

    task automatic test_single();
        wbuf[0] = 32'h0;
        bus_write(32'h10, 1, 4'hF);
        wbuf[0] = 32'hDEADBEEF;
        bus_write(32'h10, 1, 4'b0101);
        bus_read(32'h10, 1);
        checks++;
        if (readdatavalid !== 1'b0) begin failures++; $display("FAIL single_latency1: valid=%b required=0", readdatavalid); end
        @(negedge clk);
        #1;
        checks++;
        if (readdatavalid !== 1'b1) begin failures++; $display("FAIL single_latency2: valid=%b required=1", readdatavalid); end
        checks++;
        if (readdata !== 32'h00AD00EF) begin failures++; $display("FAIL single_merge: got=%h required=00ad00ef", readdata); end
        wait_drain("single");
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        bus_write(32'h100, 4, 4'hF);
        bus_read(32'h100, 4);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (k <= 3) begin
                checks++;
                if (waitrequest !== (k < 3)) begin
                    failures++;
                    $display("FAIL rburst_wait_k%0d: got=%b required=%b", k, waitrequest, (k < 3));
                end
            end
            checks++;
            if (readdatavalid !== (k >= 1)) begin
                failures++;
                $display("FAIL rburst_valid_k%0d: got=%b required=%b", k, readdatavalid, (k >= 1));
            end
        end
        wait_drain("wburst");
    endtask

    task automatic test_range();
        wbuf[0] = 32'hA1A1A1A1;
        wbuf[1] = 32'hA2A2A2A2;
        bus_write(DEPTH - 2, 2, 4'hF);
        bus_read(DEPTH - 2, 3);
        wait_drain("range_read");
        wbuf[0] = 32'hBADBAD00;
        bus_write(DEPTH, 1, 4'hF);
        bus_read(DEPTH - 1, 2);
        wait_drain("range_write");
        wbuf[0] = 32'hC1C1C1C1;
        wbuf[1] = 32'hC2C2C2C2;
        wbuf[2] = 32'hC3C3C3C3;
        bus_write(DEPTH - 1, 3, 4'hF);
        bus_read(DEPTH - 2, 3);
        wait_drain("range_wburst");
        wbuf[0] = 32'h12345678;
        bus_write(0, 1, 4'hF);
        bus_read((1 << AW) - 1, 2);
        wait_drain("range_wrap");
    endtask

    task automatic test_burst_edges();
        int n0;
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        bus_write(32'h300, 8, 4'hF);
        idle();
        n0 = nvalid;
        bus_read(32'h300, 0);
        wait_drain("count0");
        checks++;
        if (nvalid - n0 != 1) begin failures++; $display("FAIL count0_beats: got=%0d required=1", nvalid - n0); end
        n0 = nvalid;
        bus_read(32'h300, 15);
        wait_drain("count15");
        checks++;
        if (nvalid - n0 != 8) begin failures++; $display("FAIL count15_beats: got=%0d required=8", nvalid - n0); end
    endtask

    task automatic test_clken_stall();
        int n_start;
        int n0;
        n_start = nvalid;
        bus_read(32'h300, 8);
        @(negedge clk);
        clken = 1'b0;
        n0 = nvalid;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            checks++;
            if (readdatavalid !== 1'b0) begin failures++; $display("FAIL stall_valid_s%0d: got=%b required=0", s, readdatavalid); end
            checks++;
            if (waitrequest !== 1'b1) begin failures++; $display("FAIL stall_wait_s%0d: got=%b required=1", s, waitrequest); end
        end
        @(negedge clk);
        checks++;
        if (nvalid != n0) begin failures++; $display("FAIL stall_count: got=%0d required=%0d", nvalid, n0); end
        clken = 1'b1;
        wait_drain("stall");
        checks++;
        if (nvalid - n_start != 8) begin failures++; $display("FAIL stall_total: got=%0d required=8", nvalid - n_start); end
    endtask

    task automatic test_reset_mid();
        int n0;
        bus_read(32'h300, 8);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        exp_d.delete();
        exp_r.delete();
        n0 = nvalid;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_valid_s%0d: got=%b required=0", s, readdatavalid); end
            @(negedge clk);
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (nvalid != n0) begin failures++; $display("FAIL midrst_leak: valids=%0d required=%0d", nvalid, n0); end
        checks++;
        if (waitrequest !== 1'b0) begin failures++; $display("FAIL midrst_idle: waitrequest=%b required=0", waitrequest); end
        bus_read(32'h301, 1);
        checks++;
        if (readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_latency1: valid=%b required=0", readdatavalid); end
        @(negedge clk);
        #1;
        checks++;
        if (readdatavalid !== 1'b1) begin failures++; $display("FAIL midrst_latency2: valid=%b required=1", readdatavalid); end
        wait_drain("midrst");
    endtask

    initial begin
        reset_n    = 1'b0;
        clken      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = 4'hF;
        burstcount = 4'd1;
        writedata  = '0;
        test_reset();
        test_single();
        test_write_burst();
        test_range();
        test_burst_edges();
        test_clken_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
